serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_full_adder.sv | 16 +
 rtl/serial_adder.sv | 113 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default width.
package serial_adder_pkg;

  // Default operand/result width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder cell; the only arithmetic element on the operand path.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  // Pure gate-level sum and carry.
  always_comb begin
    Sum  = A ^ B ^ Cin;
    Cout = (A & B) | (Cin & (A ^ B));
  end

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: latches a, b, cin on an accepted start, then adds one bit
// pair per cycle LSB-first through a single full-adder cell.
//
// Handshake: start is sampled only while busy=0 (IDLE or DONE). The edge that
// samples start=1 in that window latches the operands. busy is high for WIDTH
// cycles, then done pulses for exactly one cycle with sum/cout final. sum/cout
// then hold until the next accepted start. There is no back-pressure.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  // Counter holds 0..WIDTH so it can never wrap inside one operation.
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_sum;
  logic fa_cout;

  // Operands are shifted right each RUN cycle, so the cell always sees bit 0.
  full_adder u_fa (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  // Next-state, datapath update and status outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done    = (state_q == ST_DONE);
        state_d = ST_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy    = 1'b1;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // After the last RUN cycle the carry register holds the final carry-out.
  always_comb begin
    sum       = sum_q;
    cout      = carry_q;
    dbg_state = state_q;
  end

endmodule : serial_adder
